detect_count_display: RTL and testbench
=======================================

// Module: detect_count_display
// PURPOSE
//  Downstream consumer of the sequence detector. Counts detections of 101101 by
//  sampling Z on every step clock (clk_to_sd) and shows the running BCD count on
//  the 4-digit multiplexed seven-segment display. Runs on the 50 MHz board clk;
//  step clock and Z are asynchronous inputs and are synchronised here.
// PARAMETERS
//  SCAN_BITS  16  refresh counter width; digit advances when counter wraps (2^16 clk)
//  SYNC_STG   2   synchroniser flops on sd_clk and Z (min 2)
// PORTS
//  clk        in   1   50 MHz board clock
//  reset      in   1   asynchronous, active-high; clears all state
//  sd_clk     in   1   step clock driving the sequence detector (clk_to_sd)
//  Z          in   1   detector output; high for one step period per detection
//  Q          in   3   detector present state (0-7)
//  an         out  4   digit enables, active-low, one-hot-low
//  seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp         out  1   decimal point, active-low
//  count_bcd  out  16  {thousands,hundreds,tens,units} BCD count
//  ovf        out  1   sticky: set when count wraps to zero
// BEHAVIOUR
//  - Reset (async, active-high): count_bcd=16'h0000, ovf=0, scan ctr=0, digit sel=0,
//    an=4'b1110, seg=7'b1000000 ('0'), dp=1, sync flops=0, z_prev=0.
//  - sd_clk and Z each pass through SYNC_STG flops -> sd_s, z_s. step_edge = sd_s & ~sd_s_d.
//  - z_prev = z_s registered each clk. On step_edge, count increments iff z_prev=1
//    (Z value from the clk cycle before the edge was seen = output of the ending step).
//  - Latency: count_bcd updates on the clk edge after step_edge, i.e. SYNC_STG+1 clk
//    after sd_clk rises. At most one increment per step_edge; Z held high over several
//    steps counts once per step.
//  - BCD increment: units 9->0 carries to tens, etc. 9999 -> 0000 and ovf<=1 (sticky
//    until reset). No invalid BCD nibble ever appears.
//  - Scan: SCAN_BITS counter free-runs; on wrap, digit sel 0->1->2->3->0.
//    an = ~(1<<sel); seg = decoded nibble for sel (0=units..3=thousands);
//    an/seg/dp registered together so no cycle shows mixed digit data.
//  - dp = 0 only when sel=0 and z_s=1 (live Z indicator); else 1.
//  - Decode (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; others blank 1111111.
//  - step_edge coincident with scan wrap: both take effect same cycle, independent.
//  - Reset asserted mid-count or mid-scan: immediate clear; first step_edge after
//    release requires sd_s to be observed low then high (no spurious count if sd_clk
//    is high at release).
//  - Q is used only under SHOW_STATE_EN; otherwise ignored.
// CONFIGURATION
//  SHOW_STATE_EN defined: digit 3 shows Q (0-7) instead of thousands; count range
//    000-999, 999 -> 000 sets ovf; count_bcd[15:12] held 0.
//  SHOW_STATE_EN undefined: 4-digit count 0000-9999 as above; Q unconnected internally.
// TESTING (bench uses SCAN_BITS=4 to shorten scan)
//  Reset: assert mid-run -> count_bcd=0000, an=1110, seg=1000000, ovf=0 within 1 clk.
//  Step 6 times with Z low -> count_bcd stays 0000; step once with Z high -> 0001
//    exactly SYNC_STG+1 clk after sd_clk rise.
//  Preload via 9999 detections (or 999 with SHOW_STATE_EN) -> next detection gives
//    0000 and ovf=1; further detection -> 0001, ovf stays 1.
//  Scan: count=0427 -> an cycles 1110,1101,1011,0111 every 16 clk with seg
//    0000010? no: 7,2,4,0 = 1111000,0100100,0011001,1000000.
//  SHOW_STATE_EN, Q=5, count=042 -> digit 3 seg=0010010, digits 2..0 show 0,4,2.
//  Release reset with sd_clk high, then hold high -> no increment; drop and raise
//    with Z high -> exactly one increment.

Source files
------------

// File: rtl/detect_count_display.sv
// ---------------------------------------------------------------------------
// detect_count_display
//
// Counts detections of the 101101 sequence detector and shows the running BCD
// count on a 4-digit multiplexed seven-segment display.
// The step clock (sd_clk) and the detector output (Z) are asynchronous to clk.
// Each is synchronised here before use.
//
// A detection is counted on a rising edge of the synchronised step clock.
// It is counted only if Z was high in the clk cycle before that edge was seen.
// That Z value is the detector output belonging to the step that just ended.
//
// Parameters
//   SCAN_BITS  refresh counter width; the display advances one digit on wrap
//   SYNC_STG   synchroniser depth for sd_clk and Z (minimum 2)
//
// Ports
//   clk        board clock (50 MHz)
//   reset      asynchronous, active-high; clears all state
//   sd_clk     step clock of the sequence detector (asynchronous)
//   Z          detector output, high for one step per detection (asynchronous)
//   Q          detector present state, shown only with SHOW_STATE_EN
//   an         digit enables, active-low, one-hot-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low; lit on digit 0 while Z is high
//   count_bcd  {thousands,hundreds,tens,units} BCD count
//   ovf        sticky wrap flag
//
// Build option
//   SHOW_STATE_EN  When defined, digit 3 shows Q, and the count is limited to
//                  3 digits (000-999). When undefined, the full 4-digit count
//                  is shown.
// ---------------------------------------------------------------------------
module detect_count_display #(
    parameter int SCAN_BITS = 16,
    parameter int SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_clk,
    input  logic        Z,
    input  logic [2:0]  Q,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] count_bcd,
    output logic        ovf
);

`ifdef SHOW_STATE_EN
    localparam int NDIG = 3;
`else
    localparam int NDIG = 4;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [SYNC_STG-1:0]  sd_sync_q, sd_sync_d;
    logic [SYNC_STG-1:0]  z_sync_q, z_sync_d;
    logic [SYNC_STG-1:0]  valid_q, valid_d;
    logic                 sd_prev_q, sd_prev_d;
    logic                 z_prev_q, z_prev_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [1:0]           sel_q, sel_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;

    logic                 sd_s, z_s, sd_valid, step_edge, scan_wrap, carry;
    logic [3:0]           digit;

    assign sd_s      = sd_sync_q[SYNC_STG-1];
    assign z_s       = z_sync_q[SYNC_STG-1];
    // The synchroniser outputs only carry real samples once SYNC_STG clocks
    // have passed since reset.
    assign sd_valid  = valid_q[SYNC_STG-1];
    // sd_prev resets high and only follows valid samples. As a result, a
    // step clock that is already high at reset release is not seen as an
    // edge. It must first be observed low.
    assign step_edge = sd_valid & sd_s & ~sd_prev_q;
    assign scan_wrap = &scan_q;

    always_comb begin
        sd_sync_d = {sd_sync_q[SYNC_STG-2:0], sd_clk};
        z_sync_d  = {z_sync_q[SYNC_STG-2:0], Z};
        valid_d   = {valid_q[SYNC_STG-2:0], 1'b1};
        sd_prev_d = sd_valid ? sd_s : sd_prev_q;
        z_prev_d  = z_s;

        // BCD ripple increment; carry out of the top digit is a wrap
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        carry = step_edge & z_prev_q;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_d[4*i +: 4] = 4'd0;
                end else begin
                    cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            ovf_d = 1'b1;
        end

        scan_d = scan_q + SCAN_BITS'(1);
        sel_d  = scan_wrap ? sel_q + 2'd1 : sel_q;

        // an, seg and dp all derive from the same sel_q and are registered
        // together, so a digit change never shows mixed data
        digit = cnt_q[{sel_q, 2'b00} +: 4];
`ifdef SHOW_STATE_EN
        // Q comes from a slow step-clock domain. A rare one-cycle glitch on
        // the display is harmless, so Q is not synchronised.
        if (sel_q == 2'd3) begin
            digit = {1'b0, Q};
        end
`endif
        an_d  = ~(4'b0001 << sel_q);
        seg_d = seg_decode(digit);
        dp_d  = ~((sel_q == 2'd0) & z_s);
    end

`ifndef SHOW_STATE_EN
    logic unused_q;
    assign unused_q = ^Q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_sync_q <= '0;
            z_sync_q  <= '0;
            valid_q   <= '0;
            sd_prev_q <= 1'b1;
            z_prev_q  <= 1'b0;
            cnt_q     <= 16'h0000;
            ovf_q     <= 1'b0;
            scan_q    <= '0;
            sel_q     <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= 7'b1000000;
            dp_q      <= 1'b1;
        end else begin
            sd_sync_q <= sd_sync_d;
            z_sync_q  <= z_sync_d;
            valid_q   <= valid_d;
            sd_prev_q <= sd_prev_d;
            z_prev_q  <= z_prev_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            scan_q    <= scan_d;
            sel_q     <= sel_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign count_bcd = cnt_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_detect_count_display.sv
// ---------------------------------------------------------------------------
// tb_detect_count_display
//
// Directed bench for detect_count_display.
// Runs with SCAN_BITS=4 and SYNC_STG=2, in the default build (4-digit count).
// Inputs are driven on falling clock edges, and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_detect_count_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd_clk;
    logic        Z;
    logic [2:0]  Q;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [15:0] count_bcd;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    detect_count_display #(
        .SCAN_BITS(4),
        .SYNC_STG (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sd_clk   (sd_clk),
        .Z        (Z),
        .Q        (Q),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .count_bcd(count_bcd),
        .ovf      (ovf)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One slow step: Z settles with sd_clk low, then sd_clk pulses high
    task automatic step(input logic zval);
        Z = zval;
        repeat (3) @(negedge clk);
        sd_clk = 1'b1;
        repeat (4) @(negedge clk);
        sd_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Fast step pulses with Z already held high: one detection each
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sd_clk = 1'b1;
            repeat (2) @(negedge clk);
            sd_clk = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    // Bounded wait for a given digit enable pattern
    task automatic wait_an(input string tag, input logic [3:0] target);
        int n = 0;
        while (an !== target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {12'h0, an}, {12'h0, target});
    endtask

    initial begin
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        exp_an[0] = 4'b1110;  exp_seg[0] = 7'b1111000;  // units 7
        exp_an[1] = 4'b1101;  exp_seg[1] = 7'b0100100;  // tens 2
        exp_an[2] = 4'b1011;  exp_seg[2] = 7'b0011001;  // hundreds 4
        exp_an[3] = 4'b0111;  exp_seg[3] = 7'b1000000;  // thousands 0

        reset  = 1'b1;
        sd_clk = 1'b0;
        Z      = 1'b0;
        Q      = 3'd5;
        repeat (3) @(negedge clk);
        chk("rst_count", count_bcd, 16'h0000);
        chk("rst_an", {12'h0, an}, 16'h000E);
        chk("rst_seg", {9'h0, seg}, {9'h0, 7'b1000000});
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_ovf", {15'h0, ovf}, 16'h0000);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Six steps with Z low: nothing counted
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("zlow_6_steps", count_bcd, 16'h0000);

        // One detection; count appears exactly 3 clk after the sd_clk rise
        Z = 1'b1;
        repeat (3) @(negedge clk);
        sd_clk = 1'b1;
        @(negedge clk);
        chk("lat_clk1", count_bcd, 16'h0000);
        @(negedge clk);
        chk("lat_clk2", count_bcd, 16'h0000);
        @(negedge clk);
        chk("lat_clk3", count_bcd, 16'h0001);
        repeat (3) @(negedge clk);
        sd_clk = 1'b0;
        repeat (3) @(negedge clk);

        // Z held high across many steps: one count per step, up to 0427
        pulses(426);
        chk("count_0427", count_bcd, 16'h0427);

        // Display scan for 0427: each digit held exactly 16 clk
        Z = 1'b0;
        repeat (4) @(negedge clk);
        wait_an("scan_sync_a", 4'b0111);
        wait_an("scan_sync_b", 4'b1110);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("scan%0d_an", k), {12'h0, an}, {12'h0, exp_an[k]});
            chk($sformatf("scan%0d_seg", k), {9'h0, seg}, {9'h0, exp_seg[k]});
            repeat (15) @(negedge clk);
            chk($sformatf("scan%0d_an_end", k), {12'h0, an}, {12'h0, exp_an[k]});
            @(negedge clk);
        end
        chk("scan_dp_zlow", {15'h0, dp}, 16'h0001);

        // Live Z indicator: dp low only on digit 0 while Z is high
        Z = 1'b1;
        wait_an("dp_sync_a", 4'b1101);
        wait_an("dp_sync_b", 4'b1110);
        chk("dp_digit0_zhigh", {15'h0, dp}, 16'h0000);
        wait_an("dp_sync_c", 4'b1101);
        chk("dp_digit1_zhigh", {15'h0, dp}, 16'h0001);

        // Preload to 9999, then wrap
        pulses(9572);
        chk("count_9999", count_bcd, 16'h9999);
        chk("ovf_before_wrap", {15'h0, ovf}, 16'h0000);
        pulses(1);
        chk("wrap_count", count_bcd, 16'h0000);
        chk("wrap_ovf", {15'h0, ovf}, 16'h0001);
        pulses(1);
        chk("after_wrap_count", count_bcd, 16'h0001);
        chk("ovf_sticky", {15'h0, ovf}, 16'h0001);

        // Mid-run reset, applied while sd_clk goes high with Z high
        sd_clk = 1'b1;
        reset  = 1'b1;
        #1;
        chk("midrst_count", count_bcd, 16'h0000);
        chk("midrst_an", {12'h0, an}, 16'h000E);
        chk("midrst_seg", {9'h0, seg}, {9'h0, 7'b1000000});
        chk("midrst_ovf", {15'h0, ovf}, 16'h0000);
        repeat (3) @(negedge clk);

        // Release with sd_clk high: no spurious count
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("release_high_nocount", count_bcd, 16'h0000);
        sd_clk = 1'b0;
        repeat (4) @(negedge clk);
        sd_clk = 1'b1;
        repeat (4) @(negedge clk);
        chk("first_real_edge", count_bcd, 16'h0001);
        sd_clk = 1'b0;
        repeat (4) @(negedge clk);
        chk("single_increment", count_bcd, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
